// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
// Digits and leading-zero blank mask stay registered until the next conversion completes.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [DIGITS-1:0]     out_blank
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_IN = (64'd1 << WIDTH) - 64'd1;

  generate
    if (pow10(DIGITS) <= MAX_IN) begin : g_digits_check
      $error("bin_to_bcd_seq: DIGITS too small to represent 2^WIDTH-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]  shift_q;
  logic [BW-1:0]     scratch_q;
  logic [CW-1:0]     count_q;

  logic              load;
  logic              step;
  logic              finish;

  logic [BW-1:0]     adj;
  logic [BW-1:0]     scratch_shift;
  logic [WIDTH-1:0]  shift_shift;
  logic [DIGITS-1:0] blank_next;
  logic              zero_above;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (count_q == CW'(1)) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Adjust is per digit with no inter-digit carry; a digit >= 5 is at most 9, so +3 fits in 4 bits.
  always_comb begin
    adj = scratch_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
      end
    end
    scratch_shift = {adj[BW-2:0], shift_q[WIDTH-1]};
    shift_shift   = shift_q << 1;

    zero_above = 1'b1;
    blank_next = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      zero_above    = zero_above & (scratch_shift[4*d +: 4] == 4'd0);
      blank_next[d] = zero_above;
    end
    blank_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      scratch_q <= '0;
      count_q   <= '0;
      out_bcd   <= '0;
      out_blank <= BLANK_RST;
    end else begin
      if (load) begin
        shift_q   <= in_bin;
        scratch_q <= '0;
        count_q   <= CW'(WIDTH);
      end else if (step) begin
        shift_q   <= shift_shift;
        scratch_q <= scratch_shift;
        count_q   <= count_q - CW'(1);
      end
      if (finish) begin
        out_bcd   <= scratch_shift;
        out_blank <= blank_next;
      end
    end
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It sits between the ALU result bus and the per-digit 7-segment decoders. It replaces the combinational divide/modulo digit split with a small iterative datapath. A valid/ready handshake is used on both sides. The converted digits and a leading-zero blank mask stay registered for the display until the next conversion completes.

## Interface
- WIDTH, 8, width of the binary input.
- DIGITS, 3, number of BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH − 1. Violation is an elaboration error.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_bin is valid this cycle.
- in_ready  output  1  converter idle; can accept in_bin.
- in_bin  input  WIDTH  unsigned binary value to convert.
- out_valid  output  1  out_bcd/out_blank hold a fresh result.
- out_ready  input  1  consumer accepts the result.
- out_bcd  output  4*DIGITS  packed BCD. Bits [3:0] are units, [7:4] tens, [11:8] hundreds, and so on.
- out_blank  output  DIGITS  bit i = 1 when digit i and all higher digits are zero. Bit 0 is always 0.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at a rising edge: latch in_bin into the shift register, clear the BCD scratch register, load the bit counter with WIDTH, and go to SHIFT.
- SHIFT:
  - in_ready = 0.
  - Each cycle, every scratch digit ≥ 5 gets +3 first. Then the concatenation {scratch, shift} shifts left by 1, with the shift register MSB entering the units LSB.
  - The counter decrements each cycle.
  - When the counter reaches 1, the current cycle's result is written to out_bcd, out_blank is computed from that same value and registered, out_valid sets, and the state goes to DONE.
- DONE:
  - out_valid = 1 and in_ready = 0.
  - On out_valid & out_ready at an edge: clear out_valid and go to IDLE.
- out_bcd and out_blank change only at the completing edge of a conversion. They hold their value through IDLE, SHIFT and DONE, so the display never shows partial results.
- Width rules:
  - The counter is $clog2(WIDTH+1) bits.
  - The scratch register is 4*DIGITS bits.
  - The +3 adjust is per 4-bit digit and never carries between digits. A digit ≥ 5 is at most 9 before adjust, so no overflow occurs.
- Boundary conditions:
  - in_valid while in SHIFT or DONE is ignored, with no queuing.
  - Changes on in_bin after acceptance have no effect.
  - If out_ready and in_valid are both high in DONE, only the output handshake completes. The input is accepted on a later edge in IDLE.
  - out_ready has no effect outside DONE.
  - Input 0 completes normally: out_bcd = 0 and out_blank = all ones except bit 0.
  - Input 2^WIDTH−1 (255 at defaults) gives 2,5,5.
- Reset (asynchronous, any state including mid-SHIFT):
  - State = IDLE, in_ready = 1, out_valid = 0.
  - out_bcd = 0, out_blank = {DIGITS-1{1'b1}, 1'b0} (3'b110 at defaults).
  - Counter, shift and scratch registers = 0.
  - An in-progress conversion is discarded.

## Timing
- Acceptance edge is E0. SHIFT runs on edges E1..E(WIDTH−1), and the result registers at edge E(WIDTH).
- out_valid is high from E(WIDTH) onward, i.e. 8 cycles after acceptance at defaults.
- With out_ready tied high, out_valid is high for exactly one cycle. The state returns to IDLE at E(WIDTH+1), and the next acceptance can occur at E(WIDTH+2).
- Maximum throughput is one conversion per WIDTH+2 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset check:
  - Stimulus: assert rst_n low asynchronously between edges.
  - Required: in_ready = 1, out_valid = 0, out_bcd = 12'h000 and out_blank = 3'b110 immediately, without waiting for a clock edge.
- Maximum value and latency:
  - Stimulus: in_bin = 255 with one-cycle in_valid and out_ready high.
  - Required: out_valid rises exactly 8 edges after acceptance, out_bcd = 12'h255, out_blank = 3'b000. The next acceptance occurs 2 edges later.
- Blanking:
  - Stimulus: convert 0, 7, 42 and 100.
  - Required: out_bcd = 000/007/042/100. out_blank = 110/110/100/000.
- Back-pressure and busy input:
  - Stimulus: convert 200 with out_ready low for 5 cycles after out_valid. Pulse in_valid with 13 during SHIFT and during DONE.
  - Required: out_valid and 12'h200 held stable, 13 never converted, in_ready low until IDLE.
- Reset mid-conversion:
  - Stimulus: convert 99, assert rst_n low at SHIFT cycle 4, release, then convert 58.
  - Required: 99 is never output, outputs show reset values, and the next result is 12'h058.
- Exhaustive sweep:
  - Stimulus: all 0..255 back-to-back with random out_ready stalls.
  - Required: each result equals the decimal split of its input in order, and out_blank matches the leading-zero rule.
